// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch / load-store memory port arbiter: FSM states,
// access-size encodings, requester ids and the LS alignment check.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BUSY_F,
        ST_BUSY_LS,
        ST_RESP_F,
        ST_RESP_LS
    } arb_state_e;

    typedef enum logic {
        RQ_F,
        RQ_LS
    } rq_id_e;

    // Same encoding as the exec-stage ldsize field.
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return addr_lo[0];
            SZ_W:    return addr_lo != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection for the memory port: load/store has priority unless fetch
// has waited through STARVE_LIMIT consecutive LS grants (0 disables the guard).
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   pick_en,
    input  logic   f_req,
    input  logic   ls_req,
    output logic   grant_valid,
    output rq_id_e grant_id
);

    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_cnt_q;
    logic [CW-1:0] starve_cnt_d;
    logic          f_forced;

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned; that is what keeps a latch from being inferred.
    always_comb begin
        f_forced     = (STARVE_LIMIT != 0) && (starve_cnt_q == LIMIT);
        grant_valid  = f_req | ls_req;
        grant_id     = RQ_F;
        starve_cnt_d = starve_cnt_q;
        if (ls_req && !(f_req && f_forced)) begin
            grant_id = RQ_LS;
        end
        if (pick_en && grant_valid) begin
            if (grant_id == RQ_F) begin
                starve_cnt_d = '0;
            end else if (f_req && (starve_cnt_q != LIMIT)) begin
                starve_cnt_d = starve_cnt_q + 1'b1;
            end
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single storage-management port between fetch and load/store,
// one outstanding access at a time. Define MEM_ARB_PERF_EN for perf counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
`ifdef MEM_ARB_PERF_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_fin,
    output logic [31:0] f_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_fin,
    output logic [31:0] ls_rdata,
    output logic        ls_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_done
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_f_grants,
    output logic [CNT_W-1:0] perf_ls_grants,
    output logic [CNT_W-1:0] perf_conflict_cycles
`endif
);

    arb_state_e  state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [1:0]  mem_size_q, mem_size_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] f_rdata_q, f_rdata_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;
    logic        err_q, err_d;

    logic        pick_en;
    logic        grant_valid;
    rq_id_e      grant_id;
    logic        ls_bad;

    assign pick_en = (state_q == ST_IDLE);
    assign ls_bad  = is_misaligned(ls_size, ls_addr[1:0]);

    mem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .clk         (clk),
        .rst         (rst),
        .pick_en     (pick_en),
        .f_req       (f_req),
        .ls_req      (ls_req),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_size_d  = mem_size_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        f_rdata_d   = f_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        err_d       = err_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    if (grant_id == RQ_F) begin
                        state_d     = ST_BUSY_F;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_size_d  = SZ_W;
                        mem_addr_d  = f_addr;
                        mem_wdata_d = '0;
                    end else if (ls_bad) begin
                        // Rejected access never reaches memory; answer directly.
                        state_d = ST_RESP_LS;
                        err_d   = 1'b1;
                    end else begin
                        state_d     = ST_BUSY_LS;
                        err_d       = 1'b0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = ls_we;
                        mem_size_d  = ls_size;
                        mem_addr_d  = ls_addr;
                        mem_wdata_d = ls_wdata;
                    end
                end
            end
            ST_BUSY_F: begin
                if (mem_done) begin
                    state_d   = ST_RESP_F;
                    f_rdata_d = mem_rdata;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end
            end
            ST_BUSY_LS: begin
                if (mem_done) begin
                    state_d    = ST_RESP_LS;
                    ls_rdata_d = mem_rdata;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                end
            end
            ST_RESP_F, ST_RESP_LS: state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_size_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            f_rdata_q   <= '0;
            ls_rdata_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_size_q  <= mem_size_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            f_rdata_q   <= f_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
            err_q       <= err_d;
        end
    end

    assign f_fin     = (state_q == ST_RESP_F);
    assign ls_fin    = (state_q == ST_RESP_LS);
    assign ls_err    = ls_fin & err_q;
    assign f_rdata   = f_rdata_q;
    assign ls_rdata  = ls_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_size  = mem_size_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

`ifdef MEM_ARB_PERF_EN
    logic [CNT_W-1:0] perf_f_q, perf_ls_q, perf_conf_q;
    logic             f_grant_evt, ls_grant_evt, conflict_evt;

    assign f_grant_evt  = pick_en && grant_valid && (grant_id == RQ_F);
    assign ls_grant_evt = pick_en && grant_valid && (grant_id == RQ_LS) && !ls_bad;
    assign conflict_evt = f_req && ls_req && (state_q != ST_RESP_F) && (state_q != ST_RESP_LS);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_f_q    <= '0;
            perf_ls_q   <= '0;
            perf_conf_q <= '0;
        end else begin
            if (f_grant_evt && (perf_f_q != '1))     perf_f_q    <= perf_f_q + 1'b1;
            if (ls_grant_evt && (perf_ls_q != '1))   perf_ls_q   <= perf_ls_q + 1'b1;
            if (conflict_evt && (perf_conf_q != '1)) perf_conf_q <= perf_conf_q + 1'b1;
        end
    end

    assign perf_f_grants        = perf_f_q;
    assign perf_ls_grants       = perf_ls_q;
    assign perf_conflict_cycles = perf_conf_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (STARVE_LIMIT=2); inputs are driven and
// outputs sampled 1 time unit after each rising clock edge.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_fin;
    logic [31:0] f_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_fin;
    logic [31:0] ls_rdata;
    logic        ls_err;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
`ifdef MEM_ARB_PERF_EN
    logic [15:0] perf_f_grants, perf_ls_grants, perf_conflict_cycles;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .STARVE_LIMIT (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_fin     (f_fin),
        .f_rdata   (f_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_size   (ls_size),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_fin    (ls_fin),
        .ls_rdata  (ls_rdata),
        .ls_err    (ls_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_size  (mem_size),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_f_grants        (perf_f_grants),
        .perf_ls_grants       (perf_ls_grants),
        .perf_conflict_cycles (perf_conflict_cycles)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] t3_addr [4] = '{32'h200, 32'h200, 32'h40, 32'h200};
    bit          t3_f    [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    int          t3_cnt  [4] = '{1, 2, 0, 0};
    logic [1:0]  t4_size [3] = '{2'b01, 2'b11, 2'b10};
    logic [31:0] t4_addr [3] = '{32'h103, 32'h100, 32'h102};
    logic        t4_we   [3] = '{1'b1, 1'b1, 1'b0};

    initial begin
        rst = 1'b1; f_req = 1'b0; f_addr = '0; ls_req = 1'b0; ls_we = 1'b0;
        ls_size = '0; ls_addr = '0; ls_wdata = '0; mem_rdata = '0; mem_done = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_size", 32'(mem_size), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_rdata", f_rdata | ls_rdata, 32'd0);
        check("rst_fins", 32'({f_fin, ls_fin, ls_err}), 32'd0);
        check("rst_starve", 32'(dut.u_pick.starve_cnt_q), 32'd0);

        // T1: fetch only, mem_done 3 cycles into mem_req
        f_req = 1'b1; f_addr = 32'h10;
        check("t1_c0_req", 32'(mem_req), 32'd0);
        step();
        check("t1_c1_req", 32'(mem_req), 32'd1);
        check("t1_c1_addr", mem_addr, 32'h10);
        check("t1_c1_wesz", 32'({mem_we, mem_size}), 32'b010);
        step();
        check("t1_c2_req", 32'(mem_req), 32'd1);
        step();
        check("t1_c3_req", 32'(mem_req), 32'd1);
        check("t1_c3_fin", 32'(f_fin), 32'd0);
        mem_done = 1'b1; mem_rdata = 32'h93;
        step();
        mem_done = 1'b0;
        check("t1_c4_fin", 32'(f_fin), 32'd1);
        check("t1_c4_rdata", f_rdata, 32'h93);
        check("t1_c4_req", 32'(mem_req), 32'd0);
        f_req = 1'b0;
        step();
        check("t1_c5_fin", 32'(f_fin), 32'd0);
        check("t1_c5_state", 32'(dut.state_q), 32'(ST_IDLE));

        // T2: fetch and 32b load together -> LS first, then fetch
        f_req = 1'b1; f_addr = 32'h20;
        ls_req = 1'b1; ls_we = 1'b0; ls_size = SZ_W; ls_addr = 32'h100;
        step();
        check("t2_c1_addr", mem_addr, 32'h100);
        check("t2_c1_req", 32'(mem_req), 32'd1);
        check("t2_c1_starve", 32'(dut.u_pick.starve_cnt_q), 32'd1);
        step();
        mem_done = 1'b1; mem_rdata = 32'hCAFE_F00D;
        step();
        mem_done = 1'b0;
        check("t2_c3_lsfin", 32'(ls_fin), 32'd1);
        check("t2_c3_ffin", 32'(f_fin), 32'd0);
        check("t2_c3_err", 32'(ls_err), 32'd0);
        check("t2_c3_rdata", ls_rdata, 32'hCAFE_F00D);
        ls_req = 1'b0;
        step();
        check("t2_c4_req", 32'(mem_req), 32'd0);
        step();
        check("t2_c5_addr", mem_addr, 32'h20);
        check("t2_c5_req", 32'(mem_req), 32'd1);
        check("t2_c5_starve", 32'(dut.u_pick.starve_cnt_q), 32'd0);
        mem_done = 1'b1; mem_rdata = 32'h13;
        step();
        mem_done = 1'b0;
        check("t2_c6_ffin", 32'(f_fin), 32'd1);
        check("t2_c6_rdata", f_rdata, 32'h13);
        f_req = 1'b0;
        step();
`ifdef MEM_ARB_PERF_EN
        check("perf_f", 32'(perf_f_grants), 32'd2);
        check("perf_ls", 32'(perf_ls_grants), 32'd1);
        check("perf_conf", 32'(perf_conflict_cycles), 32'd3);
`endif

        // T3: LS re-requests with fetch waiting, limit 2 -> LS, LS, F, LS
        f_req = 1'b1; f_addr = 32'h40;
        ls_req = 1'b1; ls_size = SZ_W; ls_addr = 32'h200;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("t3_%0d_req", i), 32'(mem_req), 32'd1);
            check($sformatf("t3_%0d_addr", i), mem_addr, t3_addr[i]);
            check($sformatf("t3_%0d_starve", i), 32'(dut.u_pick.starve_cnt_q), 32'(t3_cnt[i]));
            mem_done = 1'b1; mem_rdata = 32'h1000 + 32'(i);
            step();
            mem_done = 1'b0;
            check($sformatf("t3_%0d_fins", i), 32'({f_fin, ls_fin, ls_err}),
                  t3_f[i] ? 32'b100 : 32'b010);
            check($sformatf("t3_%0d_rdata", i), t3_f[i] ? f_rdata : ls_rdata, 32'h1000 + 32'(i));
            if (t3_f[i]) f_req = 1'b0;
            if (i == 3) ls_req = 1'b0;
            step();
        end

        // T4: rejected LS accesses answer in one cycle, memory untouched
        for (int i = 0; i < 3; i++) begin
            ls_req = 1'b1; ls_we = t4_we[i]; ls_size = t4_size[i];
            ls_addr = t4_addr[i]; ls_wdata = 32'hA5A5;
            step();
            check($sformatf("t4_%0d_fin_err", i), 32'({ls_fin, ls_err}), 32'b11);
            check($sformatf("t4_%0d_req1", i), 32'(mem_req), 32'd0);
            ls_req = 1'b0;
            step();
            check($sformatf("t4_%0d_fin2", i), 32'(ls_fin), 32'd0);
            check($sformatf("t4_%0d_req2", i), 32'(mem_req), 32'd0);
        end

        // T5: mem_done in first mem_req cycle, then spurious mem_done in IDLE
        f_req = 1'b1; f_addr = 32'h80;
        step();
        check("t5_c1_req", 32'(mem_req), 32'd1);
        mem_done = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        step();
        mem_done = 1'b0;
        check("t5_c2_fin", 32'(f_fin), 32'd1);
        check("t5_c2_rdata", f_rdata, 32'hDEAD_BEEF);
        f_req = 1'b0;
        step();
        mem_done = 1'b1; mem_rdata = 32'h5555_5555;
        step();
        mem_done = 1'b0;
        check("t5_spur_fins", 32'({f_fin, ls_fin}), 32'd0);
        check("t5_spur_state", 32'(dut.state_q), 32'(ST_IDLE));
        check("t5_spur_hold", f_rdata, 32'hDEAD_BEEF);
        step();
        check("t5_spur_fins2", 32'({f_fin, ls_fin, mem_req}), 32'd0);

        // T6: reset in BUSY_LS cycle 2 abandons the access; fresh fetch works
        ls_req = 1'b1; ls_we = 1'b0; ls_size = SZ_W; ls_addr = 32'h300;
        step();
        check("t6_c1_req", 32'(mem_req), 32'd1);
        step();
        check("t6_c2_state", 32'(dut.state_q), 32'(ST_BUSY_LS));
        rst = 1'b1;
        step();
        rst = 1'b0; ls_req = 1'b0;
        check("t6_c3_req", 32'(mem_req), 32'd0);
        check("t6_c3_state", 32'(dut.state_q), 32'(ST_IDLE));
        check("t6_c3_fin", 32'(ls_fin), 32'd0);
        check("t6_c3_rdata", f_rdata, 32'd0);
        step();
        check("t6_c4_fin", 32'(ls_fin), 32'd0);
        f_req = 1'b1; f_addr = 32'h44;
        step();
        check("t6_f_req", 32'(mem_req), 32'd1);
        check("t6_f_addr", mem_addr, 32'h44);
        mem_done = 1'b1; mem_rdata = 32'h1234;
        step();
        mem_done = 1'b0;
        check("t6_f_fin", 32'(f_fin), 32'd1);
        check("t6_f_rdata", f_rdata, 32'h1234);
        f_req = 1'b0;
        step();
        check("t6_f_idle", 32'(dut.state_q), 32'(ST_IDLE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single storage-management memory port between the fetch stage (instruction reads) and the exec stage load/store path.
- Fixed-priority arbitration with a starvation guard, one outstanding transaction at a time.
- Per-requester completion pulse matching the stage-side readFin convention.
- Sits between fetch/exec and storageMgmt; replaces direct stage-to-memory wiring.

Parameters:
- STARVE_LIMIT, 4: consecutive LS grants while fetch waits before fetch is forced to win. 0 = guard disabled, pure LS priority.
- CNT_W, 16: width of the performance counters (optional feature only).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- f_req  in  1  fetch request; held with f_addr stable until f_fin
- f_addr  in  32  fetch byte address
- f_fin  out  1  one-cycle completion pulse to fetch
- f_rdata  out  32  instruction word; valid while f_fin=1
- ls_req  in  1  load/store request; held with inputs stable until ls_fin
- ls_we  in  1  1=store, 0=load
- ls_size  in  2  00=8b, 01=16b, 10=32b, 11=illegal
- ls_addr  in  32  byte address
- ls_wdata  in  32  store data, LSB-aligned
- ls_fin  out  1  one-cycle completion pulse to exec
- ls_rdata  out  32  load data, raw from memory; valid while ls_fin=1
- ls_err  out  1  pulses with ls_fin when the access was rejected
- mem_req  out  1  memory request; held until mem_done
- mem_we  out  1  write enable
- mem_size  out  2  access size
- mem_addr  out  32  address
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data; valid with mem_done
- mem_done  in  1  one-cycle completion from memory; may assert in the first mem_req cycle

Behaviour:
- States: IDLE, BUSY_F, BUSY_LS, RESP_F, RESP_LS.
- Reset values:
  - State IDLE.
  - All *_fin, ls_err, mem_req and mem_we are 0.
  - f_rdata, ls_rdata, mem_addr, mem_wdata and mem_size are 0.
  - Starvation counter is 0.
- IDLE:
  - No request: stay in IDLE.
  - Only f_req: go to BUSY_F.
  - Only ls_req: go to BUSY_LS.
  - Both: go to BUSY_LS unless STARVE_LIMIT!=0 and starve_cnt==STARVE_LIMIT, in which case go to BUSY_F.
- Misaligned or illegal LS:
  - Condition: ls_size==11, or 16b with addr[0]=1, or 32b with addr[1:0]!=0.
  - Skips BUSY_LS and goes directly to RESP_LS with ls_err=1. Memory is never touched.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on each LS grant taken while f_req=1.
  - Clears on every fetch grant.
- Memory outputs:
  - mem_* are registered and loaded on the grant edge.
  - mem_req=1 throughout BUSY_x. Fetch grants drive mem_we=0 and mem_size=10.
- BUSY_x: on mem_done, capture mem_rdata into the granted requester's rdata register, drop mem_req on the same edge, and go to RESP_x.
- RESP_x: assert x_fin=1 for exactly one cycle, then go to IDLE.
- Latency:
  - Request seen in IDLE at cycle 0: mem_req at cycle 1, mem_done at cycle k>=1, fin at cycle k+1, IDLE at k+2.
  - Rejected LS: fin at cycle 1.
- Requester rules:
  - A requester still asserting req in the IDLE cycle after its fin is treated as a new request.
  - Requests arriving while busy wait.
  - The rdata register holds its value until overwritten.
- Ignored inputs: mem_done outside BUSY_x is ignored. Requester input changes while granted are ignored, because the mem_* signals are latched.
- Reset mid-transaction: returns to IDLE on that edge and mem_req drops. Memory must abandon the access. No fin is produced for the abandoned access.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- When defined, adds three outputs, each CNT_W wide, saturating, cleared by rst:
  - perf_f_grants: memory grants to fetch.
  - perf_ls_grants: memory grants to LS.
  - perf_conflict_cycles: cycles with f_req & ls_req both high while the state is not RESP_x.
- When undefined, these ports and counters are absent. Core behaviour is identical either way.

Decomposition:
- Package mem_arb_pkg holds:
  - The state enum.
  - Size encodings SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10, matching the exec ldsize encoding.
  - Requester id enum RQ_F / RQ_LS.
  - Function is_misaligned(size, addr[1:0]).
- One sub-module, mem_arb_pick, contains:
  - The combinational winner selection.
  - The starvation counter register.

Test Plan:
- f_req only, addr 0x0000_0010, mem_done 3 cycles after mem_req with rdata 0x0000_0093 -> mem_req cycles 1-3, f_fin at cycle 4 with f_rdata 0x0000_0093, IDLE at cycle 5.
- f_req and ls_req (load 32b @0x100) together, STARVE_LIMIT=4 -> LS granted first. Fetch granted after ls_fin. perf_conflict_cycles increments while both requests wait.
- ls_req continuously re-requesting, f_req held high, STARVE_LIMIT=2 -> pattern LS, LS, F; starve_cnt clears to 0 after the fetch grant.
- Store 16b @0x103 -> ls_fin and ls_err at cycle 1, mem_req never asserted. Repeat with size 11 -> same response.
- mem_done in the same cycle mem_req rises (k=1) -> fin at cycle 2 with correct data. Spurious mem_done in IDLE -> no fin.
- rst asserted in BUSY_LS cycle 2 -> next cycle mem_req=0, IDLE, no ls_fin. A fresh f_req afterwards completes normally.
